// File: rtl/shift_req_scheduler.sv
// Round-robin front end that time-shares one single-pass shifter among
// several requesters, splitting long shifts into bounded passes.
module shift_req_scheduler #(
  parameter int REQ_NUM         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_BIT_WIDTH = 5,
  parameter int AMT_WIDTH       = 7,
  localparam int ID_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_NUM-1:0]              iReqVld,
  output logic [REQ_NUM-1:0]              oReqRdy,
  input  logic [REQ_NUM*2-1:0]            iReqOp,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   iReqDat,
  input  logic [REQ_NUM*AMT_WIDTH-1:0]    iReqAmt,
  output logic                            oSftR,
  output logic                            oSftA,
  output logic                            oSftL,
  output logic                            oSftC,
  output logic [DATA_WIDTH-1:0]           oSftDat,
  output logic [SHIFT_BIT_WIDTH-1:0]      oSftBit,
  input  logic [DATA_WIDTH-1:0]           iSftRslt,
  output logic                            oRspVld,
  input  logic                            iRspRdy,
  output logic [DATA_WIDTH-1:0]           oRspDat,
  output logic [ID_WIDTH-1:0]             oRspId,
  output logic                            oBusy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic [AMT_WIDTH-1:0] MAX_STEP =
    AMT_WIDTH'((1 << SHIFT_BIT_WIDTH) - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQ_NUM - 1);

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [AMT_WIDTH-1:0]  rem_q, rem_d;

  logic                  found;
  logic [ID_WIDTH-1:0]   win;
  logic [AMT_WIDTH-1:0]  step;
  logic [AMT_WIDTH-1:0]  rem_nxt;
  logic                  run;
  logic                  rsp;
  logic                  accept;

  // Scan downwards so the requester closest after ptr wins last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (iReqVld[(int'(ptr_q) + k) % REQ_NUM]) begin
        found = 1'b1;
        win   = ID_WIDTH'((int'(ptr_q) + k) % REQ_NUM);
      end
    end
  end

  assign run     = (state_q == S_RUN);
  assign rsp     = (state_q == S_RSP);
  assign accept  = (state_q == S_IDLE) && found && rst_n;
  assign step    = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
  assign rem_nxt = rem_q - step;

  always_comb begin
    oReqRdy = '0;
    if (accept) oReqRdy[win] = 1'b1;
  end

  assign oSftR   = run && (op_q != 2'b10);
  assign oSftA   = run && (op_q == 2'b01);
  assign oSftL   = run && (op_q == 2'b10);
  assign oSftC   = run && (op_q == 2'b11);
  assign oSftDat = run ? work_q : '0;
  assign oSftBit = run ? step[SHIFT_BIT_WIDTH-1:0] : '0;

  assign oRspVld = rsp;
  assign oRspDat = rsp ? work_q : '0;
  assign oRspId  = rsp ? id_q : '0;
  assign oBusy   = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    work_d  = work_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          ptr_d   = (win == LAST_ID) ? '0 : win + 1'b1;
          id_d    = win;
          op_d    = iReqOp[win*2 +: 2];
          work_d  = iReqDat[win*DATA_WIDTH +: DATA_WIDTH];
          rem_d   = iReqAmt[win*AMT_WIDTH +: AMT_WIDTH];
        end
      end
      S_RUN: begin
        work_d = iSftRslt;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) state_d = S_RSP;
      end
      S_RSP: begin
        if (iRspRdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      work_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_shift_req_scheduler.sv
// Bench for shift_req_scheduler: behavioural shifter, directed cases,
// then randomized transactions against a closed-form result model.
module tb_shift_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iReqVld;
  logic [3:0]  oReqRdy;
  logic [7:0]  iReqOp;
  logic [31:0] iReqDat;
  logic [19:0] iReqAmt;
  logic        oSftR, oSftA, oSftL, oSftC;
  logic [7:0]  oSftDat;
  logic [2:0]  oSftBit;
  logic [7:0]  iSftRslt;
  logic        oRspVld;
  logic        iRspRdy;
  logic [7:0]  oRspDat;
  logic [1:0]  oRspId;
  logic        oBusy;

  logic [1:0]  op_a  [4];
  logic [7:0]  dat_a [4];
  logic [4:0]  amt_a [4];
  logic [15:0] rot16;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  assign iReqOp  = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign iReqDat = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};
  assign iReqAmt = {amt_a[3], amt_a[2], amt_a[1], amt_a[0]};

  shift_req_scheduler #(
    .REQ_NUM(4), .DATA_WIDTH(8), .SHIFT_BIT_WIDTH(3), .AMT_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iReqVld(iReqVld), .oReqRdy(oReqRdy),
    .iReqOp(iReqOp), .iReqDat(iReqDat), .iReqAmt(iReqAmt),
    .oSftR(oSftR), .oSftA(oSftA), .oSftL(oSftL), .oSftC(oSftC),
    .oSftDat(oSftDat), .oSftBit(oSftBit), .iSftRslt(iSftRslt),
    .oRspVld(oRspVld), .iRspRdy(iRspRdy),
    .oRspDat(oRspDat), .oRspId(oRspId), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // Single-pass shifter driven by the DUT controls.
  always_comb begin
    rot16    = {oSftDat, oSftDat} >> oSftBit;
    iSftRslt = oSftDat;
    if (oSftC)      iSftRslt = rot16[7:0];
    else if (oSftA) iSftRslt = 8'($signed(oSftDat) >>> oSftBit);
    else if (oSftR) iSftRslt = oSftDat >> oSftBit;
    else if (oSftL) iSftRslt = oSftDat << oSftBit;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [1:0] op,
                                         input logic [7:0] d,
                                         input int amt);
    logic [15:0] t;
    case (op)
      2'd0: return (amt >= 8) ? 8'h00 : d >> amt;
      2'd1: return (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt);
      2'd2: return (amt >= 8) ? 8'h00 : d << amt;
      default: begin
        t = {d, d} >> (amt % 8);
        return t[7:0];
      end
    endcase
  endfunction

  function automatic logic [7:0] pass_model(input logic [1:0] op,
                                            input logic [7:0] d,
                                            input int n);
    logic [15:0] t;
    case (op)
      2'd0: return d >> n;
      2'd1: return 8'($signed(d) >>> n);
      2'd2: return d << n;
      default: begin
        t = {d, d} >> n;
        return t[7:0];
      end
    endcase
  endfunction

  function automatic logic [3:0] op_ctl(input logic [1:0] op);
    case (op)
      2'd0: return 4'b1000;
      2'd1: return 4'b1100;
      2'd2: return 4'b0010;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(mptr + k) % 4]) return (mptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({oReqRdy, oSftR, oSftA, oSftL, oSftC, oSftDat, oSftBit,
                oRspVld, oRspDat, oRspId, oBusy});
  endfunction

  // Entered one tick after a rising edge with the DUT in IDLE.
  task automatic transact(input logic [3:0] vld, input int stall,
                          output logic [7:0] got, output int gid);
    int          w, p, rem, stp;
    logic [7:0]  exp, wk;
    logic [3:0]  ctl, gnt;
    w   = pick(vld);
    exp = ref_res(op_a[w], dat_a[w], int'(amt_a[w]));
    ctl = op_ctl(op_a[w]);
    rem = int'(amt_a[w]);
    wk  = dat_a[w];
    p   = (rem == 0) ? 1 : (rem + 6) / 7;
    gnt = 4'b0001 << w;
    iReqVld = vld;
    iRspRdy = 1'b0;
    #1;
    chk("idle_busy", 32'(oBusy), 0);
    chk("grant", 32'(oReqRdy), 32'(gnt));
    chk("idle_sft", 32'({oSftR, oSftA, oSftL, oSftC, oSftDat, oSftBit}), 0);
    chk("idle_rsp", 32'({oRspVld, oRspDat, oRspId}), 0);
    mptr = (w + 1) % 4;
    @(posedge clk); #1;
    for (int i = 0; i < p; i++) begin
      stp = (rem > 7) ? 7 : rem;
      chk("run_bit", 32'(oSftBit), 32'(stp));
      chk("run_dat", 32'(oSftDat), 32'(wk));
      chk("run_ctl", 32'({oSftR, oSftA, oSftL, oSftC}), 32'(ctl));
      chk("run_rdy", 32'(oReqRdy), 0);
      chk("run_busy", 32'(oBusy), 1);
      chk("run_rsp", 32'({oRspVld, oRspDat, oRspId}), 0);
      wk  = pass_model(op_a[w], wk, stp);
      rem = rem - stp;
      @(posedge clk); #1;
    end
    got = 8'h00;
    gid = -1;
    for (int s = 0; s <= stall; s++) begin
      iRspRdy = (s == stall);
      #1;
      chk("rsp_vld", 32'(oRspVld), 1);
      chk("rsp_dat", 32'(oRspDat), 32'(exp));
      chk("rsp_id", 32'(oRspId), 32'(w));
      chk("rsp_rdy", 32'(oReqRdy), 0);
      chk("rsp_busy", 32'(oBusy), 1);
      chk("rsp_sft", 32'({oSftR, oSftA, oSftL, oSftC, oSftDat, oSftBit}), 0);
      got = oRspDat;
      gid = int'(oRspId);
      @(posedge clk); #1;
    end
    iRspRdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    int         gid;
    int         order [5];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 2'd0; dat_a[i] = 8'h00; amt_a[i] = 5'd0;
    end
    rst_n   = 1'b0;
    iReqVld = 4'hF;
    iRspRdy = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_rdy", 32'(oReqRdy), 0);
    end
    rst_n   = 1'b1;
    iReqVld = 4'h0;
    #1;
    chk("rst_outs", all_out(), 0);
    @(posedge clk); #1;

    op_a[0] = 2'd0; dat_a[0] = 8'hF0; amt_a[0] = 5'd4;
    op_a[1] = 2'd1; dat_a[1] = 8'h80; amt_a[1] = 5'd10;
    op_a[2] = 2'd3; dat_a[2] = 8'h01; amt_a[2] = 5'd12;
    op_a[3] = 2'd2; dat_a[3] = 8'hFF; amt_a[3] = 5'd31;
    transact(4'b0001, 0, got, gid);
    chk("srl_f0_4", 32'(got), 32'h0F);
    chk("srl_id", 32'(gid), 0);
    transact(4'b0010, 0, got, gid);
    chk("sra_80_10", 32'(got), 32'hFF);
    transact(4'b0100, 0, got, gid);
    chk("ror_01_12", 32'(got), 32'h10);
    transact(4'b1000, 0, got, gid);
    chk("sll_ff_31", 32'(got), 32'h00);

    op_a[0] = 2'd2; dat_a[0] = 8'h5A; amt_a[0] = 5'd0;
    transact(4'b0001, 0, got, gid);
    chk("sll_amt0", 32'(got), 32'h5A);
    transact(4'b1000, 0, got, gid);

    for (int i = 0; i < 5; i++) begin
      transact(4'hF, 0, got, gid);
      chk("rr_order", 32'(gid), 32'(order[i]));
    end

    transact(4'hF, 5, got, gid);
    chk("bp_id", 32'(gid), 1);

    op_a[0] = 2'd2; dat_a[0] = 8'hFF; amt_a[0] = 5'd31;
    iReqVld = 4'b0001;
    #1;
    chk("mid_grant", 32'(oReqRdy), 32'h1);
    @(posedge clk); #1;
    chk("mid_pass1", 32'(oSftBit), 7);
    @(posedge clk); #1;
    chk("mid_pass2", 32'(oSftBit), 7);
    chk("mid_busy", 32'(oBusy), 1);
    rst_n   = 1'b0;
    iReqVld = 4'hF;
    #1;
    chk("mid_rst_rdy", 32'(oReqRdy), 0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    iReqVld = 4'h0;
    mptr    = 0;
    #1;
    chk("mid_rst_outs", all_out(), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", 32'({oRspVld, oBusy}), 0);
    end
    transact(4'hF, 0, got, gid);
    chk("rst_ptr", 32'(gid), 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        op_a[i]  = 2'($urandom_range(0, 3));
        dat_a[i] = 8'($urandom_range(0, 255));
        amt_a[i] = 5'($urandom_range(0, 31));
      end
      transact(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
               got, gid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_req_scheduler.md
SHIFT_REQ_SCHEDULER -- requirements
Module: shift_req_scheduler

Interface
REQ-001 SHALL have parameter REQ_NUM, default 4: number of requesters sharing one multi-type shifter.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: operand and result width.
REQ-003 SHALL have parameter SHIFT_BIT_WIDTH, default 5: shifter amount port width; maximum shift per pass is MAX_STEP = 2^SHIFT_BIT_WIDTH-1.
REQ-004 SHALL have parameter AMT_WIDTH, default 7: requested total shift amount width, with AMT_WIDTH >= SHIFT_BIT_WIDTH.
REQ-005 SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- iReqVld  in  REQ_NUM  per-requester request valid.
- oReqRdy  out  REQ_NUM  per-requester accept; at most one bit high.
- iReqOp  in  REQ_NUM*2  per-requester op: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
- iReqDat  in  REQ_NUM*DATA_WIDTH  per-requester operand.
- iReqAmt  in  REQ_NUM*AMT_WIDTH  per-requester total shift amount.
- oSftR, oSftA, oSftL, oSftC  out  1 each  shifter control (right/arith/left/circular).
- oSftDat  out  DATA_WIDTH  shifter operand.
- oSftBit  out  SHIFT_BIT_WIDTH  shifter amount for the current pass.
- iSftRslt  in  DATA_WIDTH  combinational shifter result for the current pass.
- oRspVld  out  1  response valid.
- iRspRdy  in  1  response ready.
- oRspDat  out  DATA_WIDTH  final shifted result.
- oRspId  out  $clog2(REQ_NUM)  index of the requester served.
- oBusy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, RSP.
REQ-007 In IDLE with any iReqVld bit high, SHALL select a winner by round-robin starting at pointer ptr, assert only oReqRdy[winner] combinationally in that cycle, and latch op, operand, amount, and id; the next state SHALL be RUN.
REQ-008 oReqRdy SHALL be all-zero in RUN and RSP; requests arriving then SHALL wait.
REQ-009 On acceptance, ptr SHALL become (winner+1) mod REQ_NUM; ptr SHALL be unchanged otherwise.
REQ-010 In RUN, each cycle SHALL drive oSftDat = working register and oSftBit = step = min(rem, MAX_STEP).
- On the clock edge, working register <= iSftRslt and rem <= rem-step.
REQ-011 Op-to-control mapping SHALL be:
- SRL: oSftR=1.
- SRA: oSftR=1, oSftA=1.
- SLL: oSftL=1.
- ROR: oSftR=1, oSftC=1.
- All other control bits SHALL be 0.
REQ-012 RUN SHALL last P = max(1, ceil(amt/MAX_STEP)) cycles.
- amt=0 executes one pass with oSftBit=0.
- RUN SHALL exit to RSP in the cycle where rem-step == 0.
REQ-013 Amounts >= DATA_WIDTH SHALL NOT be clamped; multi-pass accumulation SHALL give SRL/SLL -> 0, SRA -> sign fill, ROR -> rotation by amt mod DATA_WIDTH.
REQ-014 Outside RUN, oSftR/A/L/C, oSftDat, and oSftBit SHALL be 0.
REQ-015 In RSP, oRspVld SHALL be 1, with oRspDat = working register and oRspId = latched id, all held stable until iRspRdy=1; the handshake cycle SHALL return to IDLE.
REQ-016 Total latency SHALL be: acceptance at cycle t -> oRspVld at t+1+P; a new request is accepted no earlier than the cycle after the response handshake.
REQ-017 oRspDat and oRspId SHALL be 0 when oRspVld=0.

Reset
REQ-018 With rst_n=0 at a rising edge, the state SHALL become IDLE, ptr=0, working register=0, and rem=0.
- All outputs SHALL be 0 from the next cycle.
- Applies in any state, including mid-RUN and mid-RSP; the in-flight request SHALL be discarded with no response.
REQ-019 While rst_n=0, oReqRdy SHALL be 0 regardless of iReqVld.

Verification (REQ_NUM=4, DATA_WIDTH=8, SHIFT_BIT_WIDTH=3, AMT_WIDTH=5, MAX_STEP=7)
REQ-020 Req0 SRL, dat 0xF0, amt 4 -> oReqRdy=0001 at t; one RUN cycle with oSftBit=4; oRspVld at t+2 with oRspDat=0x0F and oRspId=0.
REQ-021 Req1 SRA, dat 0x80, amt 10 -> passes with oSftBit 7 then 3; oRspDat=0xFF at t+3.
REQ-022 Req2 ROR, dat 0x01, amt 12 -> passes 7, 5; oRspDat=0x10. Req3 SLL, dat 0xFF, amt 31 -> passes 7,7,7,7,3; oRspDat=0x00.
REQ-023 SLL with amt 0, dat 0x5A -> one RUN cycle with oSftBit=0; oRspDat=0x5A.
REQ-024 All four iReqVld held high with iRspRdy=1 and ptr=0 -> grant order 0,1,2,3,0; oReqRdy is never multi-hot; oBusy is low only in the IDLE cycles.
REQ-025 Backpressure and reset:
- iRspRdy=0 for 5 cycles in RSP -> oRspVld, oRspDat, and oRspId are held; no new oReqRdy.
- rst_n=0 during pass 2 of the amt=31 case -> the next cycle is IDLE, all outputs are 0, no response is issued, and after release ptr=0 grants req0 first.
